// File: rtl/clock_divider.sv
// Free-running binary counter clock divider: slow_clk is one counter bit,
// with single-cycle rise/fall strobes for logic that stays on the fast clock.
module clock_divider #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned BIT   = 26
) (
  input  logic             clk,
  input  logic             reset,
  output logic             slow_clk,
  output logic [WIDTH-1:0] count,
  output logic             rise_tick,
  output logic             fall_tick
);

  if (WIDTH < 1 || BIT >= WIDTH) begin : g_param_check
    $error("clock_divider: BIT must be in 0..WIDTH-1 and WIDTH >= 1");
  end

  localparam logic [BIT:0] PHASE_ONE  = (BIT+1)'(1);
  localparam logic [BIT:0] RISE_PAT   = PHASE_ONE << BIT;
  localparam logic [BIT:0] PHASE_ZERO = (BIT+1)'(0);

  logic [WIDTH-1:0] cnt;
  logic             fall_armed;

  // fall_armed blocks a fall strobe until a high phase has been seen since reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      fall_armed <= 1'b0;
    end else begin
      cnt <= cnt + WIDTH'(1);
      if (cnt[BIT]) begin
        fall_armed <= 1'b1;
      end
    end
  end

  assign slow_clk  = cnt[BIT];
  assign count     = cnt;
  assign rise_tick = (cnt[BIT:0] == RISE_PAT);
  assign fall_tick = fall_armed && (cnt[BIT:0] == PHASE_ZERO);

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench for clock_divider: three configurations share clock and reset,
// a driver queues per-cycle expectations and a negedge monitor compares them.
module tb_clock_divider;

  logic       clk_tb;
  logic       reset;

  logic       s8, r8, f8;
  logic [7:0] c8;
  logic       s40, r40, f40;
  logic [3:0] c40;
  logic       s43, r43, f43;
  logic [3:0] c43;

  clock_divider #(.WIDTH(8), .BIT(7)) u_div8 (
    .clk(clk_tb), .reset(reset), .slow_clk(s8), .count(c8),
    .rise_tick(r8), .fall_tick(f8)
  );
  clock_divider #(.WIDTH(4), .BIT(0)) u_div4_b0 (
    .clk(clk_tb), .reset(reset), .slow_clk(s40), .count(c40),
    .rise_tick(r40), .fall_tick(f40)
  );
  clock_divider #(.WIDTH(4), .BIT(3)) u_div4_b3 (
    .clk(clk_tb), .reset(reset), .slow_clk(s43), .count(c43),
    .rise_tick(r43), .fall_tick(f43)
  );

  typedef struct {
    int         ph;
    logic [7:0] c8;
    logic       s8, r8, f8;
    logic [3:0] c40;
    logic       s40, r40, f40;
    logic [3:0] c43;
    logic       s43, r43, f43;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m      = 0;
  logic ps8 = 1'b0, ps40 = 1'b0, ps43 = 1'b0;
  int   rise_n[8];
  int   fall_n[8];
  int   rise_exp[8] = '{0, 1, 1, 0, 2, 1, 0, 0};
  int   fall_exp[8] = '{0, 1, 0, 0, 2, 0, 0, 0};

  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ticks are derived from slow_clk transitions, not from counter decodes
  task automatic step(input logic rst, input int ph);
    exp_t e;
    reset = rst;
    @(posedge clk_tb);
    #1;
    m = rst ? 0 : m + 1;
    e.ph  = ph;
    e.c8  = 8'(m % 256);
    e.s8  = ((m / 128) % 2) == 1;
    e.r8  = e.s8 && !ps8;
    e.f8  = !rst && ps8 && !e.s8;
    e.c40 = 4'(m % 16);
    e.s40 = (m % 2) == 1;
    e.r40 = e.s40 && !ps40;
    e.f40 = !rst && ps40 && !e.s40;
    e.c43 = 4'(m % 16);
    e.s43 = ((m / 8) % 2) == 1;
    e.r43 = e.s43 && !ps43;
    e.f43 = !rst && ps43 && !e.s43;
    ps8  = e.s8;
    ps40 = e.s40;
    ps43 = e.s43;
    q.push_back(e);
  endtask

  task automatic run(input int n, input logic rst, input int ph);
    for (int i = 0; i < n; i++) step(rst, ph);
  endtask

  // Monitor: one expectation consumed per cycle, sampled mid-period
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_tb);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("count8", 32'(c8), 32'(e.c8));
        check("slow8",  32'(s8), 32'(e.s8));
        check("rise8",  32'(r8), 32'(e.r8));
        check("fall8",  32'(f8), 32'(e.f8));
        check("count4_b0", 32'(c40), 32'(e.c40));
        check("slow4_b0",  32'(s40), 32'(e.s40));
        check("rise4_b0",  32'(r40), 32'(e.r40));
        check("fall4_b0",  32'(f40), 32'(e.f40));
        check("count4_b3", 32'(c43), 32'(e.c43));
        check("slow4_b3",  32'(s43), 32'(e.s43));
        check("rise4_b3",  32'(r43), 32'(e.r43));
        check("fall4_b3",  32'(f43), 32'(e.f43));
        if (r8 === 1'b1) rise_n[e.ph]++;
        if (f8 === 1'b1) fall_n[e.ph]++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      rise_n[i] = 0;
      fall_n[i] = 0;
    end
    reset = 1'b1;
    run(5, 1'b1, 0);     // reset held: all outputs zero
    run(300, 1'b0, 1);   // first rise at edge 128, first fall at edge 256
    run(84, 1'b0, 2);    // lands on the second rise (count 128)
    step(1'b1, 3);       // reset while slow_clk is high
    run(600, 1'b0, 4);   // two full periods with wraps at 256 and 512
    run(167, 1'b0, 5);   // advance to count 255
    step(1'b1, 6);       // reset coincident with wrap
    run(3, 1'b0, 7);
    run(20, 1'b1, 6);    // long reset: counter pinned, no strobes
    run(10, 1'b0, 7);
    reset = 1'b0;

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk_tb);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rise_pulses_phase%0d", i), 32'(rise_n[i]), 32'(rise_exp[i]));
      check($sformatf("fall_pulses_phase%0d", i), 32'(fall_n[i]), 32'(fall_exp[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
